inverse_park_seq: RTL and testbench



---
 rtl/foc_fixed_pkg.sv | 42 ++++
 rtl/sm_mult_sat.sv | 25 ++
 rtl/inverse_park_seq.sv | 116 +++++++++++
 tb/tb_inverse_park_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_fixed_pkg.sv
// Shared fixed-point definitions for the vector-control datapath:
// 24-bit sign-magnitude Q12 words, sequencer states and the saturating adder.
package foc_fixed_pkg;

    localparam int N = 24;
    localparam int Q = 12;
    localparam logic [N-2:0] MAG_MAX = 23'h7FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        A1,
        A2,
        B1,
        B2
    } ipark_state_e;

    // Sign-magnitude add, magnitude clamped to MAG_MAX; a zero result is always +0.
    function automatic logic [N-1:0] sm_add_sat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] sum;
        logic [N-2:0] mag;
        logic         sgn;
        sum = '0;
        mag = '0;
        sgn = 1'b0;
        if (a[N-1] == b[N-1]) begin
            sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
            mag = sum[N-1] ? MAG_MAX : sum[N-2:0];
            sgn = a[N-1];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            mag = a[N-2:0] - b[N-2:0];
            sgn = a[N-1];
        end else begin
            mag = b[N-2:0] - a[N-2:0];
            sgn = b[N-1];
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        return {sgn, mag};
    endfunction

endpackage

// File: rtl/sm_mult_sat.sv
// Combinational sign-magnitude Q multiply with magnitude saturation;
// a zero product is always +0, so a -0 operand behaves as 0.
module sm_mult_sat #(
    parameter int N = 24,
    parameter int Q = 12
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] p_o
);

    logic [2*N-3:0] prod;
    logic           ovf;
    logic [N-2:0]   mag;
    logic           sgn;

    always_comb begin
        prod = {{(N-1){1'b0}}, a_i[N-2:0]} * {{(N-1){1'b0}}, b_i[N-2:0]};
        ovf  = |prod[2*N-3:N-1+Q];
        mag  = ovf ? '1 : prod[N-2+Q:Q];
        sgn  = (a_i[N-1] ^ b_i[N-1]) & (|mag);
        p_o  = {sgn, mag};
    end

endmodule

// File: rtl/inverse_park_seq.sv
// Sequential inverse Park transform: one shared multiplier stepped through
// four product terms, one result every five cycles with a valid/ready handshake.
module inverse_park_seq #(
    parameter int N = 24,
    parameter int Q = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Vd,
    input  logic [N-1:0] Vq,
    input  logic [N-1:0] SinQ,
    input  logic [N-1:0] CosQ,
    output logic         out_valid,
    output logic [N-1:0] Valpha,
    output logic [N-1:0] Vbeta
);

    import foc_fixed_pkg::*;

    ipark_state_e state_q;
    logic [N-1:0] vd_q, vq_q, sin_q, cos_q;
    logic [N-1:0] pa_q, alpha_q, pb_q;
    logic [N-1:0] valpha_q, vbeta_q;
    logic         in_ready_q, out_valid_q;

    logic [N-1:0] mul_a_d, mul_b_d, mul_p_d;
    logic [N-1:0] add_a_d, add_b_d, add_d;

    // Operand routing for the single multiplier, one product term per state.
    always_comb begin
        mul_a_d = '0;
        mul_b_d = '0;
        case (state_q)
            A1:      begin mul_a_d = vd_q; mul_b_d = cos_q; end
            A2:      begin mul_a_d = vq_q; mul_b_d = sin_q; end
            B1:      begin mul_a_d = vd_q; mul_b_d = sin_q; end
            B2:      begin mul_a_d = vq_q; mul_b_d = cos_q; end
            default: begin mul_a_d = '0;   mul_b_d = '0;    end
        endcase
    end

    sm_mult_sat #(
        .N (N),
        .Q (Q)
    ) u_mult (
        .a_i (mul_a_d),
        .b_i (mul_b_d),
        .p_o (mul_p_d)
    );

    // A2 subtracts the product (sign flipped), B2 adds it.
    always_comb begin
        add_a_d = (state_q == A2) ? pa_q : pb_q;
        add_b_d = (state_q == A2) ? {~mul_p_d[N-1], mul_p_d[N-2:0]} : mul_p_d;
        add_d   = sm_add_sat(add_a_d, add_b_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vd_q        <= '0;
            vq_q        <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            pa_q        <= '0;
            alpha_q     <= '0;
            pb_q        <= '0;
            valpha_q    <= '0;
            vbeta_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        vd_q       <= Vd;
                        vq_q       <= Vq;
                        sin_q      <= SinQ;
                        cos_q      <= CosQ;
                        in_ready_q <= 1'b0;
                        state_q    <= A1;
                    end
                end
                A1: begin
                    pa_q    <= mul_p_d;
                    state_q <= A2;
                end
                A2: begin
                    alpha_q <= add_d;
                    state_q <= B1;
                end
                B1: begin
                    pb_q    <= mul_p_d;
                    state_q <= B2;
                end
                B2: begin
                    valpha_q    <= alpha_q;
                    vbeta_q     <= add_d;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Valpha    = valpha_q;
    assign Vbeta     = vbeta_q;

endmodule

// File: tb/tb_inverse_park_seq.sv
// Self-checking bench for inverse_park_seq: directed test-plan vectors, random
// transactions against an integer reference model, back-to-back and mid-run reset.
module tb_inverse_park_seq;

    localparam longint MAXM = 64'h7FFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] Vd = '0, Vq = '0, SinQ = '0, CosQ = '0;
    logic        out_valid;
    logic [23:0] Valpha, Vbeta;

    int checks = 0;
    int errors = 0;

    inverse_park_seq #(.N(24), .Q(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Vd        (Vd),
        .Vq        (Vq),
        .SinQ      (SinQ),
        .CosQ      (CosQ),
        .out_valid (out_valid),
        .Valpha    (Valpha),
        .Vbeta     (Vbeta)
    );

    always #5 clk = ~clk;

    // Reference model: plain signed integers, clamped to the representable magnitude.
    function automatic longint ref_mul(input logic [23:0] a, input logic [23:0] b);
        longint p;
        p = (longint'(a[22:0]) * longint'(b[22:0])) / 4096;
        if (p > MAXM) p = MAXM;
        return (a[23] ^ b[23]) ? -p : p;
    endfunction

    function automatic logic [23:0] to_sm(input longint x);
        longint m;
        logic [23:0] r;
        m = (x < 0) ? -x : x;
        if (m > MAXM) m = MAXM;
        r = {1'b0, m[22:0]};
        if (x < 0 && m != 0) r[23] = 1'b1;
        return r;
    endfunction

    function automatic logic [23:0] ref_alpha(input logic [23:0] vd, vq, sn, cs);
        return to_sm(ref_mul(vd, cs) - ref_mul(vq, sn));
    endfunction

    function automatic logic [23:0] ref_beta(input logic [23:0] vd, vq, sn, cs);
        return to_sm(ref_mul(vd, sn) + ref_mul(vq, cs));
    endfunction

    function automatic logic [23:0] rand_sm();
        logic [23:0] v;
        logic        s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       v = 24'($urandom);
            1:       v = {s, 23'($urandom_range(0, 'h2000))};
            2:       v = {s, 23'($urandom_range('h7F0000, 'h7FFFFF))};
            default: v = {s, 23'h0};
        endcase
        return v;
    endfunction

    // Drives one transaction and reports what the DUT did; callers do the comparisons.
    task automatic run_txn(input logic [23:0] vd, vq, sn, cs,
                           output logic [23:0] a, b, output int lat,
                           output int rdy_low, output logic rdy_done, output logic ov_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        Vd = vd; Vq = vq; SinQ = sn; CosQ = cs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Vd = 24'($urandom); Vq = 24'($urandom); SinQ = 24'($urandom); CosQ = 24'($urandom);
        lat = 0;
        rdy_low = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
        a = Valpha;
        b = Vbeta;
        rdy_done = in_ready;
        @(posedge clk); #1;
        ov_after = out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (Valpha !== 24'h0 || Vbeta !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %06h/%06h want 000000/000000", Valpha, Vbeta);
        end
        reset = 1'b1;
        $display("reset: in_ready=%b out_valid=%b Valpha=%06h Vbeta=%06h", in_ready, out_valid, Valpha, Vbeta);
    endtask

    task automatic test_directed();
        logic [23:0] tv[5][6];
        logic [23:0] a, b;
        int          lat, rl;
        logic        rd, ova;
        tv[0] = '{24'h001000, 24'h000000, 24'h000000, 24'h001000, 24'h001000, 24'h000000};
        tv[1] = '{24'h002000, 24'h001000, 24'h000800, 24'h000800, 24'h000800, 24'h001800};
        tv[2] = '{24'h801000, 24'h001000, 24'h000800, 24'h000800, 24'h801000, 24'h000000};
        tv[3] = '{24'h7FF000, 24'h000000, 24'h000000, 24'h002000, 24'h7FFFFF, 24'h000000};
        tv[4] = '{24'h7FF000, 24'h7FF000, 24'h001000, 24'h001000, 24'h000000, 24'h7FFFFF};
        for (int i = 0; i < 5; i++) begin
            run_txn(tv[i][0], tv[i][1], tv[i][2], tv[i][3], a, b, lat, rl, rd, ova);
            $display("directed %0d: Vd=%06h Vq=%06h Sin=%06h Cos=%06h -> Valpha=%06h Vbeta=%06h lat=%0d",
                     i, tv[i][0], tv[i][1], tv[i][2], tv[i][3], a, b, lat);
            checks++;
            if (a !== tv[i][4]) begin errors++; $display("FAIL directed%0d_valpha: got %06h want %06h", i, a, tv[i][4]); end
            checks++;
            if (b !== tv[i][5]) begin errors++; $display("FAIL directed%0d_vbeta: got %06h want %06h", i, b, tv[i][5]); end
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat); end
            checks++;
            if (rl !== 4 || rd !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d_in_ready: low_cycles=%0d ready_at_result=%b want 4/1", i, rl, rd);
            end
            checks++;
            if (ova !== 1'b0) begin errors++; $display("FAIL directed%0d_pulse: out_valid after N+5=%b want 0", i, ova); end
        end
    endtask

    task automatic test_random();
        logic [23:0] vd, vq, sn, cs, a, b, ea, eb;
        int          lat, rl;
        logic        rd, ova;
        for (int i = 0; i < 25; i++) begin
            vd = rand_sm(); vq = rand_sm(); sn = rand_sm(); cs = rand_sm();
            ea = ref_alpha(vd, vq, sn, cs);
            eb = ref_beta(vd, vq, sn, cs);
            run_txn(vd, vq, sn, cs, a, b, lat, rl, rd, ova);
            $display("random %0d: Vd=%06h Vq=%06h Sin=%06h Cos=%06h -> Valpha=%06h Vbeta=%06h",
                     i, vd, vq, sn, cs, a, b);
            checks++;
            if (a !== ea) begin errors++; $display("FAIL random%0d_valpha: got %06h want %06h", i, a, ea); end
            checks++;
            if (b !== eb) begin errors++; $display("FAIL random%0d_vbeta: got %06h want %06h", i, b, eb); end
            checks++;
            if (lat !== 4 || ova !== 1'b0) begin
                errors++;
                $display("FAIL random%0d_timing: latency=%0d pulse_tail=%b want 4/0", i, lat, ova);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ops[10][4];
        logic [23:0] ea0, eb0, ea1, eb1;
        logic        exp_evt;
        int          guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) ops[k][j] = rand_sm();
        end
        ea0 = ref_alpha(ops[0][0], ops[0][1], ops[0][2], ops[0][3]);
        eb0 = ref_beta(ops[0][0], ops[0][1], ops[0][2], ops[0][3]);
        ea1 = ref_alpha(ops[5][0], ops[5][1], ops[5][2], ops[5][3]);
        eb1 = ref_beta(ops[5][0], ops[5][1], ops[5][2], ops[5][3]);
        for (int k = 0; k < 10; k++) begin
            Vd = ops[k][0]; Vq = ops[k][1]; SinQ = ops[k][2]; CosQ = ops[k][3];
            in_valid = 1'b1;
            @(posedge clk); #1;
            exp_evt = (k == 4 || k == 9);
            checks++;
            if (in_ready !== exp_evt) begin errors++; $display("FAIL b2b_in_ready_edge%0d: got %b want %b", k, in_ready, exp_evt); end
            checks++;
            if (out_valid !== exp_evt) begin errors++; $display("FAIL b2b_out_valid_edge%0d: got %b want %b", k, out_valid, exp_evt); end
            if (k >= 4 && k < 9) begin
                checks++;
                if (Valpha !== ea0 || Vbeta !== eb0) begin
                    errors++;
                    $display("FAIL b2b_result0_edge%0d: got %06h/%06h want %06h/%06h", k, Valpha, Vbeta, ea0, eb0);
                end
            end
            if (k == 4 || k == 9)
                $display("b2b result after edge %0d: Valpha=%06h Vbeta=%06h", k, Valpha, Vbeta);
        end
        checks++;
        if (Valpha !== ea1 || Vbeta !== eb1) begin
            errors++;
            $display("FAIL b2b_result1: got %06h/%06h want %06h/%06h", Valpha, Vbeta, ea1, eb1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] a, b, ea, eb;
        int          lat, rl, guard, ov_cnt;
        logic        rd, ova;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        Vd = 24'h003000; Vq = 24'h801800; SinQ = 24'h000C00; CosQ = 24'h000900;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ov_cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Valpha !== 24'h0 || Vbeta !== 24'h0) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b Valpha=%06h Vbeta=%06h want 1/0/000000/000000",
                     in_ready, out_valid, Valpha, Vbeta);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        checks++;
        if (ov_cnt !== 0) begin errors++; $display("FAIL midreset_no_pulse: out_valid pulses=%0d want 0", ov_cnt); end
        ea = ref_alpha(24'h002400, 24'h000800, 24'h800600, 24'h001000);
        eb = ref_beta(24'h002400, 24'h000800, 24'h800600, 24'h001000);
        run_txn(24'h002400, 24'h000800, 24'h800600, 24'h001000, a, b, lat, rl, rd, ova);
        $display("after reset: Valpha=%06h Vbeta=%06h lat=%0d", a, b, lat);
        checks++;
        if (a !== ea || b !== eb) begin
            errors++;
            $display("FAIL midreset_next_txn: got %06h/%06h want %06h/%06h", a, b, ea, eb);
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL midreset_latency: got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
